// File: rtl/eth_f_reset_seq_pkg.sv
// eth_f_reset_seq_pkg: state encoding and reset-vector constants for the reset sequencer
package eth_f_reset_seq_pkg;

    typedef enum logic [2:0] {
        ASSERT    = 3'd0,
        WAIT_LOCK = 3'd1,
        REL_TX    = 3'd2,
        REL_RX    = 3'd3,
        RUN       = 3'd4,
        FAIL      = 3'd5
    } state_t;

    // Reset vectors are ordered {csr, tx, rx}
    localparam logic [2:0] RST_ALL     = 3'b111;
    localparam logic [2:0] RST_RX_ONLY = 3'b001;
    localparam logic [2:0] RST_NONE    = 3'b000;

    function automatic logic [2:0] rst_of(state_t s);
        return s == REL_TX ? RST_RX_ONLY : (s == REL_RX || s == RUN) ? RST_NONE : RST_ALL;
    endfunction

endpackage

// File: rtl/eth_f_altera_std_synchronizer_nocut.sv
// eth_f_altera_std_synchronizer_nocut: multi-flop synchronizer for a single async input
module eth_f_altera_std_synchronizer_nocut #(
    parameter int   DEPTH     = 3,
    parameter logic RST_VALUE = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) q <= {DEPTH{RST_VALUE}};
        else          q <= {q[DEPTH-2:0], din};
    end

    assign dout = q[DEPTH-1];

endmodule

// File: rtl/eth_f_reset_seq_ctrl.sv
// eth_f_reset_seq_ctrl: staged, handshaked release of the CSR, TX and RX reset domains
module eth_f_reset_seq_ctrl
    import eth_f_reset_seq_pkg::*;
#(
    parameter int HOLD_CYCLES = 16,
    parameter int RDY_TIMEOUT = 1024,
    parameter int MAX_RETRY   = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pll_locked,
    input  logic       tx_ready,
    input  logic       rx_ready,
    input  logic       soft_rst_req,
    output logic       o_csr_rst,
    output logic       o_tx_rst,
    output logic       o_rx_rst,
    output logic       o_ready,
    output logic       o_fail,
    output logic [2:0] o_state,
    output logic [2:0] o_retry_cnt
);

    localparam int CNT_W = $clog2(HOLD_CYCLES > RDY_TIMEOUT ? HOLD_CYCLES : RDY_TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] HOLD_END = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] RDY_END  = CNT_W'(RDY_TIMEOUT - 1);

    logic [2:0] raw, synced;
    logic lock, tx, rx, soft_q, tmo, restart;
    logic [CNT_W-1:0] cnt;
    logic [2:0] retry, retry_inc;
    state_t state, nxt;

    assign raw = {pll_locked, tx_ready, rx_ready};
    assign {lock, tx, rx} = synced;

    for (genvar i = 0; i < 3; i++) begin : g_sync
        eth_f_altera_std_synchronizer_nocut #(.DEPTH(3), .RST_VALUE(1'b0)) u_sync (
            .clk     (clk),
            .reset_n (reset_n),
            .din     (raw[i]),
            .dout    (synced[i])
        );
    end

    assign retry_inc = retry + 3'd1;

    // Overrides are applied lowest priority first so the later ones win
    always_comb begin
        nxt = state;
        tmo = 1'b0;
        case (state)
            ASSERT:    nxt = cnt == HOLD_END ? WAIT_LOCK : ASSERT;
            WAIT_LOCK: nxt = lock ? REL_TX : WAIT_LOCK;
            REL_TX: begin
                nxt = tx ? REL_RX : REL_TX;
                tmo = !tx && cnt == RDY_END;
            end
            REL_RX: begin
                nxt = rx ? RUN : REL_RX;
                tmo = !rx && cnt == RDY_END;
            end
            RUN:       nxt = lock && tx && rx ? RUN : ASSERT;
            FAIL:      nxt = soft_rst_req && !soft_q ? ASSERT : FAIL;
            default:   nxt = ASSERT;
        endcase
        if (tmo) nxt = retry_inc == 3'(MAX_RETRY) ? FAIL : ASSERT;
        if ((state == REL_TX || state == REL_RX) && !lock) begin
            nxt = ASSERT;
            tmo = 1'b0;
        end
        if (soft_rst_req && state != FAIL) begin
            nxt = ASSERT;
            tmo = 1'b0;
        end
    end

    // A held soft request re-enters ASSERT every cycle, restarting the hold time
    assign restart = nxt != state || (soft_rst_req && state != FAIL);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state                            <= ASSERT;
            cnt                              <= '0;
            retry                            <= '0;
            soft_q                           <= 1'b0;
            {o_csr_rst, o_tx_rst, o_rx_rst}  <= RST_ALL;
            o_ready                          <= 1'b0;
            o_fail                           <= 1'b0;
        end else begin
            state                            <= nxt;
            soft_q                           <= soft_rst_req;
            cnt                              <= restart ? '0 :
                                                (state inside {ASSERT, REL_TX, REL_RX} && cnt != '1) ? cnt + 1'b1 : cnt;
            retry                            <= tmo ? retry_inc :
                                                ((nxt == RUN && state != RUN) || (state == FAIL && nxt != FAIL)) ? '0 : retry;
            {o_csr_rst, o_tx_rst, o_rx_rst}  <= rst_of(nxt);
            o_ready                          <= nxt == RUN;
            o_fail                           <= nxt == FAIL;
        end
    end

    assign o_state     = state;
    assign o_retry_cnt = retry;

endmodule
